pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central pipeline sequencer for the five-stage CPU. It drives the IF/ID hold (hazard-detect) and flush inputs, the PC write enable, the ID/EX bubble, and a whole-pipeline freeze. It detects load-use hazards and taken branches/jumps, and freezes the pipeline while a multi-cycle data-memory access is outstanding. A watchdog bounds each memory wait.

## Interface
Parameters:
- WAIT_MAX, 16, maximum cycles spent in MEM_WAIT before a timeout; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ID_rs_i  in  5  rs field of the instruction in ID
- ID_rt_i  in  5  rt field of the instruction in ID
- EX_MemRead_i  in  1  instruction in EX is a load
- EX_rt_i  in  5  destination register of the load in EX
- branch_taken_i  in  1  branch resolved taken in ID
- jump_i  in  1  jump decoded in ID
- dmem_req_i  in  1  MEM stage has a data-memory access in progress
- dmem_ack_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC update enable
- ifid_hold_o  out  1  IF/ID hold; drives the IF/ID hazard-detect input
- ifid_flush_o  out  1  zero the IF/ID instruction
- idex_bubble_o  out  1  load NOP control into ID/EX
- pipe_freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB
- mem_err_o  out  1  sticky flag: a memory wait timed out
- state_o  out  2  current state (RUN=0, MEM_WAIT=1)

## Operation
- Registered state: state (RUN or MEM_WAIT), wait_cnt[7:0], mem_err_o.
- Hazard terms (combinational):
  - lu = EX_MemRead_i & (EX_rt_i != 0) & (EX_rt_i == ID_rs_i | EX_rt_i == ID_rt_i).
  - redirect = branch_taken_i | jump_i.
  - miss = dmem_req_i & ~dmem_ack_i.
- Output priority, highest first:
  - **MEM_WAIT or miss:** pc_write=0, ifid_hold=1, pipe_freeze=1, ifid_flush=0, idex_bubble=0. Redirect and lu are ignored; they are re-evaluated once the freeze releases, because ID stays frozen.
  - **RUN with lu:** pc_write=0, ifid_hold=1, idex_bubble=1, ifid_flush=0. A redirect in the same cycle is suppressed.
  - **RUN with redirect only:** pc_write=1, ifid_flush=1, ifid_hold=0.
  - **Otherwise:** pc_write=1; all other outputs 0.
- Transitions:
  - RUN → MEM_WAIT on miss; wait_cnt loads 1.
  - In MEM_WAIT, dmem_ack_i=1 → RUN; wait_cnt clears. The ack cycle itself is still frozen.
  - In MEM_WAIT, with no ack and wait_cnt == WAIT_MAX: set mem_err_o, go to RUN, clear wait_cnt. That cycle is frozen.
  - In MEM_WAIT, with no ack and wait_cnt < WAIT_MAX: wait_cnt increments.
- ack with req in the same cycle while in RUN is a single-cycle access: no freeze, no state change.
- mem_err_o clears only on reset.

## Timing
- Reset (rst_n low, asynchronous):
  - state=RUN, wait_cnt=0, mem_err_o=0.
  - While reset is held, all outputs are forced to 0, including pc_write_o.
- The first rising edge after deassertion evaluates normally.
- Latency:
  - Hazard outputs are combinational, valid in the same cycle as their inputs.
  - state_o and mem_err_o update on the clock edge.
- Load-use: exactly one hold/bubble cycle per load, since the load leaves EX on the next edge.
- Freeze length: a miss starting at cycle t with ack at t+k freezes cycles t..t+k, i.e. k+1 cycles.
- Timeout: with no ack, the freeze lasts WAIT_MAX+1 cycles.
- Reset asserted mid-wait aborts the wait immediately: state returns to RUN and wait_cnt to 0.

## Configuration
- PIPE_HAZARD_PERF_EN defined: adds output stall_cnt_o[31:0].
  - Reset value 0.
  - Increments on every clock with pc_write_o=0 while rst_n is high.
  - Wraps from 0xFFFFFFFF to 0.
- PIPE_HAZARD_PERF_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset:
  - Assert rst_n=0 mid-MEM_WAIT → state_o=0 and all outputs 0 immediately.
  - After release with idle inputs → pc_write_o=1.
- Load-use:
  - Stimulus: EX_MemRead_i=1, EX_rt_i=5, ID_rs_i=5.
  - Response: one cycle of pc_write=0, ifid_hold=1, idex_bubble=1.
  - Same stimulus with EX_rt_i=0 → no stall.
- Branch:
  - branch_taken_i=1 alone → ifid_flush_o=1, pc_write_o=1 for 1 cycle.
  - branch_taken_i=1 together with lu → flush=0, bubble=1.
- Memory wait:
  - dmem_req_i=1, ack asserted on the 4th cycle → pipe_freeze_o=1 for 4 cycles, state_o=1 for 3 cycles, then RUN.
  - stall_cnt_o increases by 4 (only when built with PIPE_HAZARD_PERF_EN).
- Timeout:
  - WAIT_MAX=3, dmem_req_i held, no ack → freeze lasts 4 cycles, then mem_err_o=1 and state_o=0.
  - mem_err_o stays 1 until reset.
- Single-cycle access: req=1 and ack=1 in the same cycle → no freeze, state_o stays 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, branch/jump flush, and data-memory freeze with a wait watchdog.
// Optional build macro PIPE_HAZARD_PERF_EN adds a free-running stall-cycle counter (stall_cnt_o).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal issue; hazards resolved combinationally
// MEM_WAIT | data-memory access outstanding; whole pipeline frozen

module pipeline_hazard_ctrl #(
   parameter int WAIT_MAX = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] ID_rs_i,
   input  logic [4:0] ID_rt_i,
   input  logic       EX_MemRead_i,
   input  logic [4:0] EX_rt_i,
   input  logic       branch_taken_i,
   input  logic       jump_i,
   input  logic       dmem_req_i,
   input  logic       dmem_ack_i,
   output logic       pc_write_o,
   output logic       ifid_hold_o,
   output logic       ifid_flush_o,
   output logic       idex_bubble_o,
   output logic       pipe_freeze_o,
   output logic       mem_err_o,
   output logic [1:0] state_o
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [31:0] stall_cnt_o
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1
   } state_t;

   localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       mem_err_nxt;
   logic       lu, redirect, miss;

   assign lu       = EX_MemRead_i && (EX_rt_i != 5'd0) &&
                     ((EX_rt_i == ID_rs_i) || (EX_rt_i == ID_rt_i));
   assign redirect = branch_taken_i | jump_i;
   assign miss     = dmem_req_i & ~dmem_ack_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         wait_cnt  <= 8'd0;
         mem_err_o <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         mem_err_o <= mem_err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      mem_err_nxt  = mem_err_o;
      case (state)
         RUN: begin
            if (miss) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (dmem_ack_i) begin
               state_nxt    = RUN;
               wait_cnt_nxt = 8'd0;
            end else if (wait_cnt == WAIT_LIMIT) begin
               state_nxt    = RUN;
               wait_cnt_nxt = 8'd0;
               mem_err_nxt  = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = 8'd0;
         end
      endcase
   end

   // Outputs are held low for the whole reset window, including pc_write_o.
   always_comb begin
      pc_write_o    = 1'b0;
      ifid_hold_o   = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_freeze_o = 1'b0;
      if (rst_n) begin
         if ((state == MEM_WAIT) || miss) begin
            ifid_hold_o   = 1'b1;
            pipe_freeze_o = 1'b1;
         end else if (lu) begin
            ifid_hold_o   = 1'b1;
            idex_bubble_o = 1'b1;
         end else if (redirect) begin
            pc_write_o   = 1'b1;
            ifid_flush_o = 1'b1;
         end else begin
            pc_write_o = 1'b1;
         end
      end
   end

   assign state_o = state;

`ifdef PIPE_HAZARD_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_o <= 32'd0;
      end else if (!pc_write_o) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the sequencing rules.
module tb_pipeline_hazard_ctrl;

   localparam int WAIT_MAX = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] ID_rs_i, ID_rt_i, EX_rt_i;
   logic       EX_MemRead_i, branch_taken_i, jump_i, dmem_req_i, dmem_ack_i;
   logic       pc_write_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o, mem_err_o;
   logic [1:0] state_o;
`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] stall_cnt_o;
`endif

   pipeline_hazard_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ID_rs_i       (ID_rs_i),
      .ID_rt_i       (ID_rt_i),
      .EX_MemRead_i  (EX_MemRead_i),
      .EX_rt_i       (EX_rt_i),
      .branch_taken_i(branch_taken_i),
      .jump_i        (jump_i),
      .dmem_req_i    (dmem_req_i),
      .dmem_ack_i    (dmem_ack_i),
      .pc_write_o    (pc_write_o),
      .ifid_hold_o   (ifid_hold_o),
      .ifid_flush_o  (ifid_flush_o),
      .idex_bubble_o (idex_bubble_o),
      .pipe_freeze_o (pipe_freeze_o),
      .mem_err_o     (mem_err_o),
      .state_o       (state_o)
`ifdef PIPE_HAZARD_PERF_EN
      ,
      .stall_cnt_o   (stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // model: number of frozen cycles already spent in the current memory episode (0 = none)
   int          m_frozen = 0;
   bit          m_err    = 0;
   logic [31:0] m_stall  = 0;
   logic [7:0]  last_obs;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // {state[1:0], mem_err, pc_write, ifid_hold, ifid_flush, idex_bubble, pipe_freeze}
   function automatic logic [7:0] model_out();
      bit waiting, lu, redirect, miss;
      logic pc, hold, flush, bubble, freeze;
      waiting  = (m_frozen > 0);
      lu       = EX_MemRead_i && (EX_rt_i != 0) && (EX_rt_i == ID_rs_i || EX_rt_i == ID_rt_i);
      redirect = branch_taken_i || jump_i;
      miss     = dmem_req_i && !dmem_ack_i;
      pc = 1; hold = 0; flush = 0; bubble = 0; freeze = 0;
      if (waiting || miss) begin
         pc = 0; hold = 1; freeze = 1;
      end else if (lu) begin
         pc = 0; hold = 1; bubble = 1;
      end else if (redirect) begin
         flush = 1;
      end
      return {1'b0, waiting, m_err, pc, hold, flush, bubble, freeze};
   endfunction

   function automatic logic [7:0] observed();
      return {state_o, mem_err_o, pc_write_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};
   endfunction

   // Inputs are already applied; check mid-cycle, then advance the model across the edge.
   task automatic cycle(input string tag);
      logic [7:0] exp;
      #1;
      exp      = model_out();
      last_obs = observed();
      check(tag, {24'd0, last_obs}, {24'd0, exp});
`ifdef PIPE_HAZARD_PERF_EN
      check({tag, "_stall"}, stall_cnt_o, m_stall);
`endif
      @(posedge clk);
      if (!exp[4]) m_stall++;
      if (exp[0]) begin
         if (m_frozen > 0 && dmem_ack_i) m_frozen = 0;
         else if (m_frozen + 1 == WAIT_MAX + 1) begin
            m_err    = 1;
            m_frozen = 0;
         end else m_frozen++;
      end
      #1;
   endtask

   task automatic idle();
      ID_rs_i = 0; ID_rt_i = 0; EX_rt_i = 0; EX_MemRead_i = 0;
      branch_taken_i = 0; jump_i = 0; dmem_req_i = 0; dmem_ack_i = 0;
   endtask

   initial begin
      int frz, wst;
      logic [31:0] s0;
      rst_n = 0;
      idle();
      #2;
      check("reset_outs", {24'd0, observed()}, 32'd0);
      #10 rst_n = 1;              // t=12, between edges
      cycle("idle0");
      check("idle_pc", {31'd0, last_obs[4]}, 32'd1);

      // load-use: one hold/bubble cycle, then the load leaves EX
      EX_MemRead_i = 1; EX_rt_i = 5; ID_rs_i = 5;
      cycle("lu");
      check("lu_stall", {29'd0, last_obs[4], last_obs[3], last_obs[1]}, 32'b011);
      idle();
      cycle("lu_after");
      check("lu_release_pc", {31'd0, last_obs[4]}, 32'd1);
      EX_MemRead_i = 1; EX_rt_i = 0; ID_rs_i = 0;
      cycle("lu_r0");
      check("lu_r0_nostall", {30'd0, last_obs[4], last_obs[3]}, 32'b10);

      idle(); branch_taken_i = 1;
      cycle("br");
      check("br_flush", {30'd0, last_obs[4], last_obs[2]}, 32'b11);
      EX_MemRead_i = 1; EX_rt_i = 7; ID_rt_i = 7;
      cycle("br_lu");
      check("br_lu_prio", {30'd0, last_obs[2], last_obs[1]}, 32'b01);

      // memory wait acked on the 4th cycle
      idle(); frz = 0; wst = 0;
      s0 = m_stall;
      dmem_req_i = 1;
      for (int i = 0; i < 4; i++) begin
         dmem_ack_i = (i == 3);
         cycle("mw");
         frz += int'(last_obs[0]);
         wst += int'(last_obs[6]);
      end
      idle();
      cycle("mw_after");
      check("mw_freeze_len", frz, 4);
      check("mw_state_len", wst, 3);
      check("mw_back_run", {30'd0, last_obs[7:6]}, 32'd0);
`ifdef PIPE_HAZARD_PERF_EN
      check("mw_stall_delta", stall_cnt_o - s0, 32'd4);
`endif

      dmem_req_i = 1; dmem_ack_i = 1;
      cycle("single");
      check("single_nofreeze", {31'd0, last_obs[0]}, 32'd0);
      idle();
      cycle("single_after");
      check("single_state", {30'd0, last_obs[7:6]}, 32'd0);

      // watchdog timeout
      frz = 0; dmem_req_i = 1;
      for (int i = 0; i < WAIT_MAX + 1; i++) begin
         cycle("to");
         frz += int'(last_obs[0]);
      end
      idle();
      cycle("to_after");
      check("to_freeze_len", frz, WAIT_MAX + 1);
      check("to_err_state", {29'd0, last_obs[7:5]}, 32'b001);
      for (int i = 0; i < 3; i++) cycle("to_sticky");
      check("to_err_sticky", {31'd0, last_obs[5]}, 32'd1);

      // reset in the middle of a wait
      dmem_req_i = 1;
      cycle("rw0");
      cycle("rw1");
      check("rw_in_wait", {30'd0, last_obs[7:6]}, 32'd1);
      rst_n = 0;
      #1;
      check("rw_async_outs", {24'd0, observed()}, 32'd0);
`ifdef PIPE_HAZARD_PERF_EN
      check("rw_stall_clr", stall_cnt_o, 32'd0);
`endif
      m_frozen = 0; m_err = 0; m_stall = 0;
      #2 rst_n = 1;
      idle();
      cycle("rw_release");
      check("rw_release_pc", {31'd0, last_obs[4]}, 32'd1);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         ID_rs_i        = 5'($urandom_range(0, 3));
         ID_rt_i        = 5'($urandom_range(0, 3));
         EX_rt_i        = 5'($urandom_range(0, 3));
         EX_MemRead_i   = ($urandom_range(0, 1) == 1);
         branch_taken_i = ($urandom_range(0, 3) == 0);
         jump_i         = ($urandom_range(0, 6) == 0);
         dmem_req_i     = ($urandom_range(0, 3) == 0) || (m_frozen > 0);
         dmem_ack_i     = ($urandom_range(0, 3) == 0);
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
